// File: rtl/upload_arbiter_pkg.sv
// Shared types and constants for the upload arbiter: FSM encoding, source
// indices and datapath widths.
package upload_arbiter_pkg;

  localparam int unsigned IDX_W  = 2;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned HO_W   = 4;

  localparam int unsigned SRC_UART = 0;
  localparam int unsigned SRC_SPI  = 1;
  localparam int unsigned SRC_I2C  = 2;
  localparam int unsigned SRC_DSM  = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

endpackage

// File: rtl/upload_arbiter_rr_select.sv
// Round-robin requester selection: first set bit of req starting one past last.
module rr_select
  import upload_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               found,
  output logic [IDX_W-1:0]   index
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest requester is written last and wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int unsigned k = NUM_SRC; k > 0; k--) begin
      cand = IDX_W'((32'(last) + k) % NUM_SRC);
      if (req[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/upload_arbiter.sv
// Merges per-source upload byte streams into one command_processor port,
// granting one whole packet at a time in round-robin order.
module upload_arbiter
  import upload_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned HOLDOFF_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_req,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [BYTE_W*NUM_SRC-1:0] src_data,
  input  logic [BYTE_W*NUM_SRC-1:0] src_source,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic                      up_req,
  output logic                      up_valid,
  output logic [BYTE_W-1:0]         up_data,
  output logic [BYTE_W-1:0]         up_source,
  input  logic                      up_ready,
  output logic                      grant_active,
  output logic [IDX_W-1:0]          grant_id,
  output logic [CNT_W-1:0]          grant_bytes,
  output logic                      timeout_pulse
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   grant_bytes_q, grant_bytes_d;
  logic [CNT_W-1:0]   to_cnt_q, to_cnt_d;
  logic [HO_W-1:0]    ho_cnt_q, ho_cnt_d;
  logic               timeout_pulse_q, timeout_pulse_d;

  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic               in_grant;
  logic               xfer;
  logic [BYTE_W-1:0]  data_arr  [NUM_SRC];
  logic [BYTE_W-1:0]  srcid_arr [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign data_arr[i]  = src_data[BYTE_W*i +: BYTE_W];
    assign srcid_arr[i] = src_source[BYTE_W*i +: BYTE_W];
  end

  rr_select #(.NUM_SRC(NUM_SRC)) u_rr_select (
    .req   (src_req),
    .last  (last_grant_q),
    .found (sel_found),
    .index (sel_idx)
  );

  assign in_grant = (state_q == ST_GRANT);
  assign xfer     = in_grant && src_valid[grant_id_q] && up_ready;

  // Zero-latency mux from the owning source; forced to zero while in reset.
  always_comb begin
    up_req    = 1'b0;
    up_valid  = 1'b0;
    up_data   = '0;
    up_source = '0;
    src_ready = '0;
    if (in_grant && !rst) begin
      up_req                = src_req[grant_id_q];
      up_valid              = src_valid[grant_id_q];
      up_data               = data_arr[grant_id_q];
      up_source             = srcid_arr[grant_id_q];
      src_ready[grant_id_q] = up_ready;
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_id_d      = grant_id_q;
    last_grant_d    = last_grant_q;
    grant_bytes_d   = grant_bytes_q;
    to_cnt_d        = to_cnt_q;
    ho_cnt_d        = ho_cnt_q;
    timeout_pulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          grant_id_d    = sel_idx;
          last_grant_d  = sel_idx;
          grant_bytes_d = '0;
          to_cnt_d      = '0;
          state_d       = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (xfer) begin
          to_cnt_d = '0;
          if (grant_bytes_q != '1) grant_bytes_d = grant_bytes_q + CNT_W'(1);
        end else begin
          to_cnt_d = to_cnt_q + CNT_W'(1);
        end
        // A trailing valid byte with req already low still goes out before release.
        if (!src_req[grant_id_q] && !src_valid[grant_id_q]) begin
          ho_cnt_d = '0;
          state_d  = ST_HOLDOFF;
        end else if (!xfer && (to_cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES)) begin
          ho_cnt_d        = '0;
          timeout_pulse_d = 1'b1;
          state_d         = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (ho_cnt_q == HO_W'(HOLDOFF_CYCLES - 1)) state_d = ST_IDLE;
        else ho_cnt_d = ho_cnt_q + HO_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      grant_id_q      <= '0;
      last_grant_q    <= IDX_W'(NUM_SRC - 1);
      grant_bytes_q   <= '0;
      to_cnt_q        <= '0;
      ho_cnt_q        <= '0;
      timeout_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      grant_id_q      <= grant_id_d;
      last_grant_q    <= last_grant_d;
      grant_bytes_q   <= grant_bytes_d;
      to_cnt_q        <= to_cnt_d;
      ho_cnt_q        <= ho_cnt_d;
      timeout_pulse_q <= timeout_pulse_d;
    end
  end

  assign grant_active  = in_grant;
  assign grant_id      = grant_id_q;
  assign grant_bytes   = grant_bytes_q;
  assign timeout_pulse = timeout_pulse_q;

endmodule

// File: tb/tb_upload_arbiter.sv
// Directed bench for upload_arbiter: a per-cycle vector table plus
// hand-written multi-cycle sequences for round-robin, timeout and reset.
module tb_upload_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  src_req, src_valid, src_ready;
  logic [31:0] src_data, src_source;
  logic        up_req, up_valid, up_ready;
  logic [7:0]  up_data, up_source;
  logic        grant_active, timeout_pulse;
  logic [1:0]  grant_id;
  logic [15:0] grant_bytes;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  upload_arbiter #(.NUM_SRC(4), .TIMEOUT_CYCLES(8), .HOLDOFF_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .src_req(src_req), .src_valid(src_valid), .src_data(src_data),
    .src_source(src_source), .src_ready(src_ready),
    .up_req(up_req), .up_valid(up_valid), .up_data(up_data),
    .up_source(up_source), .up_ready(up_ready),
    .grant_active(grant_active), .grant_id(grant_id),
    .grant_bytes(grant_bytes), .timeout_pulse(timeout_pulse)
  );

  typedef struct {
    logic [3:0]  req, valid;
    logic [31:0] data;
    logic        rdy;
    logic        e_req, e_val;
    logic [7:0]  e_data, e_src;
    logic [3:0]  e_rdy;
    logic        e_ga;
    logic [1:0]  e_gid;
    logic [15:0] e_bytes;
  } vec_t;

  vec_t tbl [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic do_reset();
    rst = 1'b1; src_req = '0; src_valid = '0; up_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_grant(input int budget, input string name);
    int n = 0;
    while (!grant_active && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(grant_active), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [1:0] g;
    logic [7:0] pk [4];
    int idx;
    int cyc;

    src_source = 32'h5352_5150;
    src_data   = '0;

    //            req   val   data          rdy  ereq eval edata  esrc   erdy  ga gid bytes
    tbl[0]  = '{4'h1, 4'h1, 32'hEEDDCCA1, 1'b1, 0, 0, 8'h00, 8'h00, 4'h0, 0, 0, 16'd0};
    tbl[1]  = '{4'h1, 4'h1, 32'hEEDDCCA1, 1'b1, 1, 1, 8'hA1, 8'h50, 4'h1, 1, 0, 16'd0};
    tbl[2]  = '{4'h1, 4'h1, 32'hEEDDCCA2, 1'b1, 1, 1, 8'hA2, 8'h50, 4'h1, 1, 0, 16'd1};
    tbl[3]  = '{4'h0, 4'h1, 32'hEEDDCCA3, 1'b1, 0, 1, 8'hA3, 8'h50, 4'h1, 1, 0, 16'd2};
    tbl[4]  = '{4'h0, 4'h0, 32'hEEDDCCA3, 1'b1, 0, 0, 8'hA3, 8'h50, 4'h1, 1, 0, 16'd3};
    tbl[5]  = '{4'h2, 4'h2, 32'hEEDDB1A3, 1'b1, 0, 0, 8'h00, 8'h00, 4'h0, 0, 0, 16'd3};
    tbl[6]  = '{4'h2, 4'h2, 32'hEEDDB1A3, 1'b1, 0, 0, 8'h00, 8'h00, 4'h0, 0, 0, 16'd3};
    tbl[7]  = '{4'h2, 4'h2, 32'hEEDDB1A3, 1'b0, 1, 1, 8'hB1, 8'h51, 4'h0, 1, 1, 16'd0};
    tbl[8]  = '{4'h2, 4'h2, 32'hEEDDB1A3, 1'b1, 1, 1, 8'hB1, 8'h51, 4'h2, 1, 1, 16'd0};
    tbl[9]  = '{4'h0, 4'h0, 32'hEEDDB1A3, 1'b1, 0, 0, 8'hB1, 8'h51, 4'h2, 1, 1, 16'd1};
    tbl[10] = '{4'h0, 4'h0, 32'hEEDDB1A3, 1'b1, 0, 0, 8'h00, 8'h00, 4'h0, 0, 1, 16'd1};

    // Reset state, including zeroed combinational outputs while rst is high.
    rst = 1'b1; src_req = 4'hF; src_valid = 4'hF; up_ready = 1'b1;
    tick(); tick();
    chk("rst_up_req", 32'(up_req), 32'd0);
    chk("rst_src_ready", 32'(src_ready), 32'd0);
    chk("rst_grant_active", 32'(grant_active), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_grant_bytes", 32'(grant_bytes), 32'd0);
    chk("rst_timeout_pulse", 32'(timeout_pulse), 32'd0);
    rst = 1'b0;

    // Cycle-by-cycle table: UART 3-byte packet, holdoff, SPI packet with backpressure.
    for (int i = 0; i < 11; i++) begin
      if (i > 0) tick();
      src_req = tbl[i].req; src_valid = tbl[i].valid;
      src_data = tbl[i].data; up_ready = tbl[i].rdy;
      #2;
      chk($sformatf("t%0d_up_req", i), 32'(up_req), 32'(tbl[i].e_req));
      chk($sformatf("t%0d_up_valid", i), 32'(up_valid), 32'(tbl[i].e_val));
      chk($sformatf("t%0d_up_data", i), 32'(up_data), 32'(tbl[i].e_data));
      chk($sformatf("t%0d_up_source", i), 32'(up_source), 32'(tbl[i].e_src));
      chk($sformatf("t%0d_src_ready", i), 32'(src_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("t%0d_grant_active", i), 32'(grant_active), 32'(tbl[i].e_ga));
      chk($sformatf("t%0d_grant_id", i), 32'(grant_id), 32'(tbl[i].e_gid));
      chk($sformatf("t%0d_grant_bytes", i), 32'(grant_bytes), 32'(tbl[i].e_bytes));
      chk($sformatf("t%0d_timeout_pulse", i), 32'(timeout_pulse), 32'd0);
    end

    // All four sources requesting: 2-byte packets granted 0,1,2,3,0.
    do_reset();
    src_req = 4'hF; src_valid = 4'hF; src_data = 32'hE3E2E1E0;
    for (int p = 0; p < 5; p++) begin
      g = 2'(p % 4);
      wait_grant(8, $sformatf("rr%0d_grant", p));
      chk($sformatf("rr%0d_grant_id", p), 32'(grant_id), 32'(g));
      for (int b = 0; b < 2; b++) begin
        src_data[{g, 3'b000} +: 8] = 8'(8'h10 * (g + 1) + b);
        #2;
        chk($sformatf("rr%0d_b%0d_data", p, b), 32'(up_data), 32'(8'h10 * (g + 1) + b));
        chk($sformatf("rr%0d_b%0d_src", p, b), 32'(up_source), 32'(8'h50 + g));
        chk($sformatf("rr%0d_b%0d_ready", p, b), 32'(src_ready), 32'(4'b1 << g));
        tick();
      end
      src_req[g] = 1'b0; src_valid[g] = 1'b0;
      #2;
      chk($sformatf("rr%0d_rel_up_req", p), 32'(up_req), 32'd0);
      tick();
      chk($sformatf("rr%0d_hold_active", p), 32'(grant_active), 32'd0);
      chk($sformatf("rr%0d_hold_bytes", p), 32'(grant_bytes), 32'd2);
      src_req[g] = 1'b1; src_valid[g] = 1'b1;
    end

    // SPI requests mid-UART-packet: waits, then wins after holdoff.
    do_reset();
    src_req = 4'h1; src_valid = 4'h1; src_data = 32'h0000_5AC0;
    wait_grant(4, "np_grant0");
    src_req = 4'h3; src_valid = 4'h3;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk($sformatf("np%0d_src_ready", c), 32'(src_ready), 32'h1);
      chk($sformatf("np%0d_up_data", c), 32'(up_data), 32'hC0);
      tick();
    end
    src_req = 4'h2; src_valid = 4'h2;
    #2;
    chk("np_rel_src_ready", 32'(src_ready), 32'h1);
    tick();
    chk("np_holdoff_active", 32'(grant_active), 32'd0);
    chk("np_holdoff_ready", 32'(src_ready), 32'h0);
    tick();
    chk("np_idle_active", 32'(grant_active), 32'd0);
    tick();
    #2;
    chk("np_spi_active", 32'(grant_active), 32'd1);
    chk("np_spi_id", 32'(grant_id), 32'd1);
    chk("np_spi_ready", 32'(src_ready), 32'h2);
    chk("np_spi_data", 32'(up_data), 32'h5A);

    // Timeout after 8 idle grant cycles.
    do_reset();
    src_req = 4'h1; src_valid = 4'h0;
    tick();
    for (int c = 1; c <= 8; c++) begin
      #2;
      chk($sformatf("to_c%0d_active", c), 32'(grant_active), 32'd1);
      chk($sformatf("to_c%0d_pulse", c), 32'(timeout_pulse), 32'd0);
      tick();
    end
    chk("to_release_active", 32'(grant_active), 32'd0);
    chk("to_pulse", 32'(timeout_pulse), 32'd1);
    chk("to_up_req", 32'(up_req), 32'd0);
    tick();
    chk("to_pulse_clear", 32'(timeout_pulse), 32'd0);
    chk("to_idle_active", 32'(grant_active), 32'd0);
    tick();
    chk("to_regrant", 32'(grant_active), 32'd1);
    src_req = 4'h0;
    tick(); tick();

    // Toggling up_ready during a 4-byte packet.
    do_reset();
    pk[0] = 8'hD1; pk[1] = 8'hD2; pk[2] = 8'hD3; pk[3] = 8'hD4;
    src_req = 4'h1; src_valid = 4'h1; src_data = 32'h0000_00D1;
    wait_grant(4, "bp_grant");
    idx = 0; cyc = 0;
    while (idx < 4 && cyc < 12) begin
      up_ready = (cyc % 2 == 0);
      src_data[7:0] = pk[idx];
      #2;
      chk($sformatf("bp%0d_data", cyc), 32'(up_data), 32'(pk[idx]));
      chk($sformatf("bp%0d_ready", cyc), 32'(src_ready), 32'(up_ready));
      if (up_ready) idx++;
      tick();
      cyc++;
    end
    up_ready = 1'b1; src_req = 4'h0; src_valid = 4'h0;
    tick();
    chk("bp_bytes", 32'(grant_bytes), 32'd4);
    chk("bp_released", 32'(grant_active), 32'd0);

    // Reset during an I2C grant.
    do_reset();
    src_req = 4'h4; src_valid = 4'h4; src_data = 32'h0077_0000;
    wait_grant(4, "mr_grant");
    chk("mr_grant_id", 32'(grant_id), 32'd2);
    tick();
    rst = 1'b1;
    #2;
    chk("mr_up_req", 32'(up_req), 32'd0);
    chk("mr_up_valid", 32'(up_valid), 32'd0);
    chk("mr_up_data", 32'(up_data), 32'd0);
    chk("mr_up_source", 32'(up_source), 32'd0);
    chk("mr_src_ready", 32'(src_ready), 32'd0);
    tick();
    chk("mr_active", 32'(grant_active), 32'd0);
    chk("mr_grant_id_clr", 32'(grant_id), 32'd0);
    chk("mr_bytes_clr", 32'(grant_bytes), 32'd0);
    rst = 1'b0; src_req = 4'hF; src_valid = 4'h0;
    tick();
    chk("mr_next_active", 32'(grant_active), 32'd1);
    chk("mr_next_id", 32'(grant_id), 32'd0);
    src_req = 4'h0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
